bound_flasher_ctrl: RTL and testbench
=====================================

# bound_flasher_ctrl

Sequencing controller for the bound-flasher LED path. It drives the 2-bit `led_bhv` command into the sibling up/down LED counter and reads back that counter's `count`. It walks the counter through the six-phase flash pattern and applies flick-triggered kickbacks. It also decodes `count` into the thermometer LED vector seen at the board pins.

## Interface
Parameters:
- LED_NUMBER, 16, number of LEDs; full-on count value
- LED_NUMBER_W, $clog2(LED_NUMBER), counter index width; `count` is LED_NUMBER_W+1 bits
- MID_LO, 6, first bound / low kickback point, as a lit-LED count
- MID_HI, 11, second bound / high kickback point, as a lit-LED count

Ports:
- div_clk  in  1  divided clock, shared with the counter
- rst  in  1  asynchronous, active-high reset, shared with the counter
- flick  in  1  start / kickback request, sampled on div_clk
- count  in  LED_NUMBER_W+1  current lit-LED count from the counter
- led_bhv  out  2  counter command: 01 INC, 00 DEC, 11 PASS; 10 never driven
- led  out  LED_NUMBER  thermometer decode: led[i] = (count > i)
- busy  out  1  high whenever state != IDLE
- phase  out  3  state encoding, for debug

## Operation
- States and their direction / target:
  - IDLE: PASS
  - UP1: INC to MID_LO
  - DN1: DEC to 0
  - UP2: INC to MID_HI
  - DN2: DEC to MID_LO-1
  - UP3: INC to LED_NUMBER
  - DN3: DEC to 0
- `led_bhv` is combinational from (state, count, flick), so the counter and the state register move on the same edge.
- Target reached (INC states: count >= target; DEC states: count <= target): advance to the next state and output that state's direction in the same cycle. There is no dwell cycle at a bound.
- Phase order: UP1 → DN1 → UP2 → DN2 → UP3 → DN3 → IDLE.
- IDLE behaviour:
  - count != 0: output DEC and do not start.
  - count == 0 and flick=1: output INC and go to UP1.
  - Otherwise: PASS.
- DN3 at count==0: go to IDLE with PASS. If flick=1 at that edge, go directly to UP1 with INC (restart).
- Kickback (only when compiled in, see Configuration), while not at the current state's target:
  - UP2 with flick=1 and count==MID_LO: go to DN1, output DEC.
  - UP3 with flick=1 and count==MID_LO or count==MID_HI: go to DN2, output DEC.
- flick is ignored in UP1, DN1, DN2 and DN3, except for the DN3→IDLE restart.
- Widths: all comparisons are unsigned at LED_NUMBER_W+1 bits. MID_LO-1 is a compile-time constant.

## Timing
- Reset (async, immediate): state=IDLE, busy=0, phase=0. The counter also clears, so led=0 and led_bhv=PASS (while flick=0).
- Reset mid-pattern aborts it. The first edge after deassertion with flick=1 starts UP1.
- Uninterrupted pattern: 56 counting edges from the start edge, then one edge in DN3 at count 0 to return to IDLE. busy falls on edge 57.
- Each peak or trough count is held for exactly one cycle.
- Kickback latency: zero. The decrement happens on the same edge that samples flick.

## Configuration
- BOUND_FLASHER_KICKBACK_EN defined: kickback rules are active as in Operation.
- Not defined: flick only starts the pattern (IDLE) or restarts it (DN3 at 0). UP2 and UP3 always run to their targets.

## Structure
- Shared package `bound_flasher_pkg` holds:
  - LED_BHV_INC/DEC/PASS localparams, matching the counter's encoding
  - state enum `bf_state_t`
  - default MID_LO/MID_HI constants
- Sub-module `led_thermo_decoder` (count → led), parameterised by LED_NUMBER.
- The counter is instantiated beside this block at the top level, not inside it.

## Test plan
- Reset with flick=0 → led=0, busy=0, led_bhv=11. Assert rst mid-UP3 at count=9 → led=0 and phase=IDLE immediately.
- One-cycle flick pulse, then flick=0 → count sequence 0↗6↘0↗11↘5↗16↘0. busy falls 57 edges after the start edge. led_bhv is never 10.
- KICKBACK_EN, flick=1 during UP2 when count==6 → next count 5, phase=DN1. The pattern then continues down to 0 and into UP2.
- KICKBACK_EN, flick=1 during UP3 when count==11 → next count 10, phase=DN2, down to 5, then UP3 again.
- Without KICKBACK_EN, the same stimuli → UP2 reaches 11 and UP3 reaches 16 unaltered.
- flick held at 1 continuously with no kickback build → at DN3 count 0, next state is UP1 with count 1, with no IDLE cycle.

Source files
------------

// File: rtl/bound_flasher_pkg.sv
// Shared definitions for the bound-flasher LED path: counter command encoding,
// controller state type and default bound points.
package bound_flasher_pkg;

  localparam logic [1:0] LED_BHV_INC  = 2'b01;
  localparam logic [1:0] LED_BHV_DEC  = 2'b00;
  localparam logic [1:0] LED_BHV_PASS = 2'b11;

  localparam int MID_LO_DEF = 6;
  localparam int MID_HI_DEF = 11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UP1  = 3'd1,
    ST_DN1  = 3'd2,
    ST_UP2  = 3'd3,
    ST_DN2  = 3'd4,
    ST_UP3  = 3'd5,
    ST_DN3  = 3'd6
  } bf_state_t;

  // Counter direction a state imposes while it is running.
  function automatic logic [1:0] bf_dir(input bf_state_t s);
    case (s)
      ST_UP1, ST_UP2, ST_UP3: return LED_BHV_INC;
      ST_DN1, ST_DN2, ST_DN3: return LED_BHV_DEC;
      default:                return LED_BHV_PASS;
    endcase
  endfunction

endpackage

// File: rtl/led_thermo_decoder.sv
// Thermometer decode of the lit-LED count: led[i] is on when count > i.
module led_thermo_decoder #(
  parameter int LED_NUMBER   = 16,
  parameter int LED_NUMBER_W = $clog2(LED_NUMBER)
) (
  input  logic [LED_NUMBER_W:0] count,
  output logic [LED_NUMBER-1:0] led
);

  always_comb begin
    led = '0;
    for (int unsigned i = 0; i < LED_NUMBER; i++) begin
      led[i] = (count > (LED_NUMBER_W+1)'(i));
    end
  end

endmodule

// File: rtl/bound_flasher_ctrl.sv
// Six-phase sequencing controller for the bound-flasher LED counter.
// Define BOUND_FLASHER_KICKBACK_EN to enable flick-triggered kickbacks in UP2/UP3.
module bound_flasher_ctrl
  import bound_flasher_pkg::*;
#(
  parameter int LED_NUMBER   = 16,
  parameter int LED_NUMBER_W = $clog2(LED_NUMBER),
  parameter int MID_LO       = MID_LO_DEF,
  parameter int MID_HI       = MID_HI_DEF
) (
  input  logic                  div_clk,
  input  logic                  rst,
  input  logic                  flick,
  input  logic [LED_NUMBER_W:0] count,
  output logic [1:0]            led_bhv,
  output logic [LED_NUMBER-1:0] led,
  output logic                  busy,
  output logic [2:0]            phase
);

  localparam logic [LED_NUMBER_W:0] C_LO    = (LED_NUMBER_W+1)'(MID_LO);
  localparam logic [LED_NUMBER_W:0] C_LO_M1 = (LED_NUMBER_W+1)'(MID_LO - 1);
  localparam logic [LED_NUMBER_W:0] C_HI    = (LED_NUMBER_W+1)'(MID_HI);
  localparam logic [LED_NUMBER_W:0] C_FULL  = (LED_NUMBER_W+1)'(LED_NUMBER);

  bf_state_t r_state;
  bf_state_t w_state_nx;
  logic      w_zero;
  logic      w_kick_up2;
  logic      w_kick_up3;

  assign w_zero = (count == '0);

`ifdef BOUND_FLASHER_KICKBACK_EN
  assign w_kick_up2 = flick && (count == C_LO);
  assign w_kick_up3 = flick && ((count == C_LO) || (count == C_HI));
`else
  assign w_kick_up2 = 1'b0;
  assign w_kick_up3 = 1'b0;
`endif

  // Target checks take priority over kickbacks; a bound advances without dwelling.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: if (w_zero && flick) w_state_nx = ST_UP1;
      ST_UP1:  if (count >= C_LO) w_state_nx = ST_DN1;
      ST_DN1:  if (w_zero) w_state_nx = ST_UP2;
      ST_UP2: begin
        if (count >= C_HI)   w_state_nx = ST_DN2;
        else if (w_kick_up2) w_state_nx = ST_DN1;
      end
      ST_DN2:  if (count <= C_LO_M1) w_state_nx = ST_UP3;
      ST_UP3: begin
        if (count >= C_FULL) w_state_nx = ST_DN3;
        else if (w_kick_up3) w_state_nx = ST_DN2;
      end
      ST_DN3:  if (w_zero) w_state_nx = flick ? ST_UP1 : ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // The command follows the state being entered, so counter and FSM move together.
  always_comb begin
    if (w_state_nx == ST_IDLE) led_bhv = w_zero ? LED_BHV_PASS : LED_BHV_DEC;
    else                       led_bhv = bf_dir(w_state_nx);
  end

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  assign busy  = (r_state != ST_IDLE);
  assign phase = r_state;

  led_thermo_decoder #(
    .LED_NUMBER   (LED_NUMBER),
    .LED_NUMBER_W (LED_NUMBER_W)
  ) u_thermo (
    .count (count),
    .led   (led)
  );

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Self-checking bench for bound_flasher_ctrl with a behavioural up/down counter
// beside it and a rule-level reference model of the flash pattern.
module tb_bound_flasher_ctrl;

  localparam int LN  = 16;
  localparam int LW  = 4;
  localparam int MLO = 6;
  localparam int MHI = 11;

`ifdef BOUND_FLASHER_KICKBACK_EN
  localparam bit KB = 1'b1;
`else
  localparam bit KB = 1'b0;
`endif

  logic          div_clk = 1'b0;
  logic          rst     = 1'b0;
  logic          flick   = 1'b0;
  logic [LW:0]   count;
  logic [1:0]    led_bhv;
  logic [LN-1:0] led;
  logic          busy;
  logic [2:0]    phase;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase index 0=IDLE, 1..6 = UP1,DN1,UP2,DN2,UP3,DN3.
  int m_ph  = 0;
  int m_cnt = 0;
  int tgt[7] = '{0, MLO, 0, MHI, MLO - 1, LN, 0};
  bit up[7]  = '{0, 1, 0, 1, 0, 1, 0};

  always #5 div_clk = ~div_clk;

  bound_flasher_ctrl #(
    .LED_NUMBER   (LN),
    .LED_NUMBER_W (LW),
    .MID_LO       (MLO),
    .MID_HI       (MHI)
  ) dut (
    .div_clk (div_clk),
    .rst     (rst),
    .flick   (flick),
    .count   (count),
    .led_bhv (led_bhv),
    .led     (led),
    .busy    (busy),
    .phase   (phase)
  );

  // Sibling counter: 01 increment, 00 decrement, anything else holds.
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) count <= '0;
    else if (led_bhv == 2'b01) count <= count + 1'b1;
    else if (led_bhv == 2'b00 && count != '0) count <= count - 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] thermo(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic void ref_step(input int ph, input int cnt, input bit fl,
                                   output int nph, output int ncnt);
    bit reached;
    if (ph == 0) begin
      if (cnt != 0)  begin nph = 0; ncnt = cnt - 1; end
      else if (fl)   begin nph = 1; ncnt = 1;       end
      else           begin nph = 0; ncnt = 0;       end
      return;
    end
    reached = up[ph] ? (cnt >= tgt[ph]) : (cnt <= tgt[ph]);
    if (reached) begin
      nph  = (ph == 6) ? (fl ? 1 : 0) : ph + 1;
      ncnt = (nph == 0) ? cnt : (up[nph] ? cnt + 1 : cnt - 1);
    end else if (KB && fl && ((ph == 3 && cnt == MLO) ||
                              (ph == 5 && (cnt == MLO || cnt == MHI)))) begin
      nph  = ph - 1;
      ncnt = cnt - 1;
    end else begin
      nph  = ph;
      ncnt = up[ph] ? cnt + 1 : cnt - 1;
    end
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit fl);
    int         nph;
    int         ncnt;
    logic [1:0] eb;
    flick = fl;
    #1;
    ref_step(m_ph, m_cnt, fl, nph, ncnt);
    if (nph == 0) eb = (m_cnt == 0) ? 2'b11 : 2'b00;
    else          eb = (ncnt > m_cnt) ? 2'b01 : 2'b00;
    chk("led_bhv", led_bhv, eb);
    @(posedge div_clk);
    m_ph  = nph;
    m_cnt = ncnt;
    @(negedge div_clk);
    chk("count", count, m_cnt);
    chk("phase", phase, m_ph);
    chk("busy", busy, m_ph != 0);
    chk("led", led, thermo(m_cnt));
  endtask

  task automatic do_reset();
    flick = 1'b0;
    rst   = 1'b1;
    #1;
    m_ph  = 0;
    m_cnt = 0;
    chk("rst_led", led, 0);
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bhv", led_bhv, 2'b11);
    @(negedge div_clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_q[$];
    int peaks[6] = '{MLO, 0, MHI, MLO - 1, LN, 0};
    int v;
    int fell_at;

    @(negedge div_clk);
    do_reset();

    // Single-pulse uninterrupted pattern against an explicit count sequence.
    v = 0;
    foreach (peaks[i]) begin
      while (v != peaks[i]) begin
        v += (peaks[i] > v) ? 1 : -1;
        exp_q.push_back(v);
      end
    end
    exp_q.push_back(0);
    fell_at = 0;
    for (int k = 1; k <= 70 && fell_at == 0; k++) begin
      cycle(k == 1);
      if (k <= exp_q.size()) chk("seq_count", count, exp_q[k-1]);
      if (!busy) fell_at = k;
    end
    chk("busy_fall_edge", fell_at, 57);

    // Reset in the middle of UP3 at count 9.
    cycle(1'b1);
    for (int b = 0; b < 100 && !(m_ph == 5 && m_cnt == 9); b++) cycle(1'b0);
    chk("reach_up3_9", (m_ph == 5 && m_cnt == 9), 1);
    #2;
    do_reset();

    // Flick in UP2 at count MID_LO.
    cycle(1'b1);
    for (int b = 0; b < 100 && !(m_ph == 3 && m_cnt == MLO); b++) cycle(1'b0);
    chk("reach_up2_lo", (m_ph == 3 && m_cnt == MLO), 1);
    cycle(1'b1);
`ifdef BOUND_FLASHER_KICKBACK_EN
    chk("kick_up2_count", count, MLO - 1);
    chk("kick_up2_phase", phase, 2);
`else
    chk("nokick_up2_count", count, MLO + 1);
    chk("nokick_up2_phase", phase, 3);
`endif
    for (int b = 0; b < 100 && !(m_ph == 5 && m_cnt == MHI); b++) cycle(1'b0);
    chk("reach_up3_hi", (m_ph == 5 && m_cnt == MHI), 1);
    cycle(1'b1);
`ifdef BOUND_FLASHER_KICKBACK_EN
    chk("kick_up3_count", count, MHI - 1);
    chk("kick_up3_phase", phase, 4);
`else
    chk("nokick_up3_count", count, MHI + 1);
    chk("nokick_up3_phase", phase, 5);
`endif
    for (int b = 0; b < 100 && m_ph != 0; b++) cycle(1'b0);
    chk("back_to_idle", m_ph, 0);

`ifndef BOUND_FLASHER_KICKBACK_EN
    // flick held high: DN3 at 0 restarts straight into UP1.
    for (int b = 0; b < 100 && !(m_ph == 6 && m_cnt == 0); b++) cycle(1'b1);
    chk("reach_dn3_0", (m_ph == 6 && m_cnt == 0), 1);
    cycle(1'b1);
    chk("restart_phase", phase, 1);
    chk("restart_count", count, 1);
    do_reset();
`endif

    // Random flick traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) do_reset();
      else cycle($urandom_range(7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
